// File: rtl/conv1d_stream_mac.sv
// conv1d_stream_mac: streaming int8 1-D convolution MAC engine.
// Computes one output point (kernel_len taps x input_depth channels) as a
// dot product of the filter buffer against a circular input buffer, LANES
// products per cycle, then hands the int32 accumulator to the quant block.
module conv1d_stream_mac #(
  parameter int LANES        = 8,
  parameter int MAX_KERNEL   = 8,
  parameter int MAX_CHANNELS = 128,
  parameter int FILT_DEPTH   = MAX_KERNEL * MAX_CHANNELS,
  parameter int RING_DEPTH   = (MAX_KERNEL + 1) * MAX_CHANNELS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [6:0]  cmd,
  input  logic [31:0] inp0,
  input  logic [31:0] inp1,
  output logic [31:0] ret,
  output logic        busy,
  output logic        quant_start,
  output logic [31:0] quant_acc,
  input  logic        quant_done,
  input  logic [31:0] quant_ret
);

  localparam int KW  = $clog2(MAX_KERNEL + 1);
  localparam int DW  = $clog2(MAX_CHANNELS + 1);
  localparam int PW  = $clog2(RING_DEPTH + 2 * LANES) + 1;
  localparam int FAW = $clog2(FILT_DEPTH);
  localparam int RAW = $clog2(RING_DEPTH);

  localparam logic [6:0] CMD_INFO    = 7'd0;
  localparam logic [6:0] CMD_WR_RING = 7'd1;
  localparam logic [6:0] CMD_WR_FILT = 7'd2;
  localparam logic [6:0] CMD_OFFSET  = 7'd3;
  localparam logic [6:0] CMD_DEPTH   = 7'd5;
  localparam logic [6:0] CMD_START   = 7'd6;
  localparam logic [6:0] CMD_RESULT  = 7'd7;
  localparam logic [6:0] CMD_STARTX  = 7'd8;
  localparam logic [6:0] CMD_STATUS  = 7'd9;
  localparam logic [6:0] CMD_KERNEL  = 7'd10;
  localparam logic [6:0] CMD_ACC     = 7'd11;
  localparam logic [6:0] CMD_ABORT   = 7'd12;
  localparam logic [6:0] CMD_CLR     = 7'd13;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, QUANT} state_t;

  logic [7:0] ring_mem [RING_DEPTH];
  logic [7:0] filt_mem [FILT_DEPTH];

  state_t        state;
  logic          done;
  logic          error;
  logic [31:0]   acc;
  logic [31:0]   result;
  logic [9:0]    input_offset;
  logic [DW-1:0] input_depth;
  logic [KW-1:0] kernel_len;
  logic [31:0]   start_x;
  logic [PW-1:0] k;
  logic [PW-1:0] in_ptr;
  logic [31:0]   psum;
  logic          psum_valid;

  logic [PW-1:0] total;
  logic [PW-1:0] ring_size;
  logic [PW-1:0] ptr_step;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] start_ptr;
  logic          start_ok;
  logic          depth_ok;
  logic          kernel_ok;
  logic          abort;

  logic [LANES-1:0][17:0] lane_prod;
  logic [31:0]            lane_sum;

  logic              wr_cmd;
  logic              wr_filt;
  logic [3:0][32:0]  wr_addr;
  logic [3:0]        wr_en;
  logic              wr_drop;

  assign busy      = (state != IDLE);
  assign quant_acc = acc;
  assign abort     = (cmd == CMD_ABORT);

  assign total     = {{(PW-KW){1'b0}}, kernel_len} * {{(PW-DW){1'b0}}, input_depth};
  assign ring_size = total + {{(PW-DW){1'b0}}, input_depth};
  assign start_ptr = {{(PW-KW){1'b0}}, start_x[KW-1:0]} * {{(PW-DW){1'b0}}, input_depth};
  assign ptr_step  = in_ptr + PW'(LANES);
  assign ptr_next  = (ptr_step >= ring_size) ? ptr_step - ring_size : ptr_step;

  assign start_ok  = (start_x <= 32'(kernel_len)) && (ring_size >= PW'(LANES));
  assign depth_ok  = (inp1 != 32'd0) && (inp1 <= 32'(MAX_CHANNELS));
  assign kernel_ok = (inp1 != 32'd0) && (inp1 <= 32'(MAX_KERNEL));

  // One product per lane; lanes past the last tap contribute zero. Since
  // ring_size >= LANES, one conditional subtract keeps the ring index in range.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic        [PW-1:0]  fidx;
    logic        [PW-1:0]  rsum;
    logic        [RAW-1:0] ridx;
    logic signed [7:0]     fval;
    logic signed [7:0]     rval;
    logic signed [9:0]     xval;
    logic signed [17:0]    raw_prod;

    assign fidx     = k + PW'(g);
    assign rsum     = in_ptr + PW'(g);
    assign ridx     = RAW'((rsum >= ring_size) ? rsum - ring_size : rsum);
    assign fval     = (fidx < PW'(FILT_DEPTH)) ? filt_mem[FAW'(fidx)] : 8'h00;
    assign rval     = ring_mem[ridx];
    assign xval     = {{2{rval[7]}}, rval} + input_offset;
    assign raw_prod = fval * xval;
    assign lane_prod[g] = (fidx < total) ? raw_prod : 18'd0;
  end

  // Sign-extend each 18-bit product and add them into one beat sum.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + {{14{lane_prod[i][17]}}, lane_prod[i]};
  end

  // Decode buffer writes: bytes beyond the buffer end are dropped and flagged.
  assign wr_cmd  = en && !busy && ((cmd == CMD_WR_RING) || (cmd == CMD_WR_FILT));
  assign wr_filt = (cmd == CMD_WR_FILT);

  always_comb begin
    wr_en   = '0;
    wr_drop = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wr_addr[j] = {1'b0, inp0} + 33'(j);
      if (wr_cmd) begin
        if (wr_addr[j] < (wr_filt ? 33'(FILT_DEPTH) : 33'(RING_DEPTH)))
          wr_en[j] = 1'b1;
        else
          wr_drop = 1'b1;
      end
    end
  end

  // Buffer storage is never cleared, so it is written without a reset branch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 4; j++) begin
        if (wr_en[j]) begin
          if (wr_filt)
            filt_mem[FAW'(wr_addr[j])] <= inp1[8*j +: 8];
          else
            ring_mem[RAW'(wr_addr[j])] <= inp1[8*j +: 8];
        end
      end
    end
  end

  // Control FSM, two-stage MAC pipeline and command decode; commands are
  // handled after the FSM so abort overrides whatever the FSM scheduled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ret          <= '0;
      quant_start  <= 1'b0;
      done         <= 1'b1;
      error        <= 1'b0;
      acc          <= '0;
      result       <= '0;
      input_offset <= '0;
      input_depth  <= DW'(1);
      kernel_len   <= KW'(MAX_KERNEL);
      start_x      <= '0;
      k            <= '0;
      in_ptr       <= '0;
      psum         <= '0;
      psum_valid   <= 1'b0;
    end else if (en) begin
      ret         <= '0;
      quant_start <= 1'b0;
      psum_valid  <= 1'b0;
      if (psum_valid)
        acc <= acc + psum;

      case (state)
        MAC: begin
          psum       <= lane_sum;
          psum_valid <= 1'b1;
          k          <= k + PW'(LANES);
          in_ptr     <= ptr_next;
          if (k + PW'(LANES) >= total)
            state <= DRAIN;
        end
        DRAIN: begin
          quant_start <= 1'b1;
          state       <= QUANT;
        end
        QUANT: begin
          if (quant_done && !abort) begin
            result <= quant_ret;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: ;
      endcase

      case (cmd)
        CMD_INFO:    ret <= 32'(FILT_DEPTH);
        CMD_WR_RING,
        CMD_WR_FILT: if (busy || wr_drop) error <= 1'b1;
        CMD_OFFSET:  if (busy) error <= 1'b1; else input_offset <= inp1[9:0];
        CMD_DEPTH:   if (busy || !depth_ok) error <= 1'b1; else input_depth <= DW'(inp1);
        CMD_START: begin
          if (busy || !start_ok) begin
            error <= 1'b1;
          end else begin
            acc        <= '0;
            k          <= '0;
            in_ptr     <= start_ptr;
            done       <= 1'b0;
            psum_valid <= 1'b0;
            state      <= MAC;
          end
        end
        CMD_RESULT:  ret <= result;
        CMD_STARTX:  if (busy) error <= 1'b1; else start_x <= inp1;
        CMD_STATUS:  ret <= {30'b0, error, done};
        CMD_KERNEL:  if (busy || !kernel_ok) error <= 1'b1; else kernel_len <= KW'(inp1);
        CMD_ACC:     ret <= acc;
        CMD_ABORT: begin
          state       <= IDLE;
          done        <= 1'b1;
          quant_start <= 1'b0;
          psum_valid  <= 1'b0;
        end
        CMD_CLR:     error <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_stream_mac.sv
// Testbench for conv1d_stream_mac: directed and randomized convolutions
// compared against a plain-arithmetic reference model, with the bench
// acting as the downstream quant block.
module tb_conv1d_stream_mac;

  localparam int LANES        = 8;
  localparam int MAX_KERNEL   = 8;
  localparam int MAX_CHANNELS = 128;
  localparam int FILT_DEPTH   = MAX_KERNEL * MAX_CHANNELS;
  localparam int RING_DEPTH   = (MAX_KERNEL + 1) * MAX_CHANNELS;
  localparam logic [6:0] NOP  = 7'd127;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [6:0]  cmd;
  logic [31:0] inp0;
  logic [31:0] inp1;
  logic [31:0] ret;
  logic        busy;
  logic        quant_start;
  logic [31:0] quant_acc;
  logic        quant_done;
  logic [31:0] quant_ret;

  conv1d_stream_mac #(
    .LANES(LANES), .MAX_KERNEL(MAX_KERNEL), .MAX_CHANNELS(MAX_CHANNELS),
    .FILT_DEPTH(FILT_DEPTH), .RING_DEPTH(RING_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
    .ret(ret), .busy(busy), .quant_start(quant_start), .quant_acc(quant_acc),
    .quant_done(quant_done), .quant_ret(quant_ret)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: buffer images and configuration as the bench wrote them.
  byte         filt_m [FILT_DEPTH];
  byte         ring_m [RING_DEPTH];
  int          m_kernel;
  int          m_depth;
  int          m_offset;
  int          m_startx;
  bit          m_error;
  logic [31:0] last_result;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h (%0d) expected 0x%08h (%0d)",
             tag, observed, $signed(observed), expected, $signed(expected));
    end
  endtask

  // One command cycle; returns the registered response seen one cycle later.
  task automatic applyStimulus(input logic [6:0] c, input logic [31:0] a,
                               input logic [31:0] v, output logic [31:0] r);
    @(negedge clk);
    en = 1'b1; cmd = c; inp0 = a; inp1 = v;
    @(negedge clk);
    r = ret;
    cmd = NOP; inp0 = '0; inp1 = '0;
  endtask

  task automatic modelReset();
    m_kernel = MAX_KERNEL; m_depth = 1; m_offset = 0; m_startx = 0;
    m_error = 1'b0; last_result = '0;
  endtask

  // Dot product over kernel_len*input_depth taps, ring read circularly.
  function automatic logic [31:0] modelConv();
    int total = m_kernel * m_depth;
    int rs    = (m_kernel + 1) * m_depth;
    int sum   = 0;
    for (int t = 0; t < total; t++)
      sum += int'(filt_m[t]) * (int'(ring_m[(m_startx * m_depth + t) % rs]) + m_offset);
    return sum;
  endfunction

  task automatic writeWord(input bit to_filt, input int addr, input logic [31:0] w);
    logic [31:0] r;
    applyStimulus(to_filt ? 7'd2 : 7'd1, addr, w, r);
    for (int j = 0; j < 4; j++) begin
      if (to_filt && (addr + j < FILT_DEPTH)) filt_m[addr + j] = w[8*j +: 8];
      else if (!to_filt && (addr + j < RING_DEPTH)) ring_m[addr + j] = w[8*j +: 8];
      else m_error = 1'b1;
    end
  endtask

  // kind 0: constant param, 1: index+param, other: random bytes.
  task automatic fillBuf(input bit to_filt, input int count, input int kind, input int param);
    logic [31:0] w;
    for (int a = 0; a < count; a += 4) begin
      for (int j = 0; j < 4; j++) begin
        case (kind)
          0:       w[8*j +: 8] = 8'(param);
          1:       w[8*j +: 8] = 8'(a + j + param);
          default: w[8*j +: 8] = 8'($urandom);
        endcase
      end
      writeWord(to_filt, a, w);
    end
  endtask

  task automatic configure(input int kl, input int d, input int off, input int sx);
    logic [31:0] r;
    applyStimulus(7'd10, 0, 32'(kl), r);
    applyStimulus(7'd5, 0, 32'(d), r);
    applyStimulus(7'd3, 0, 32'(off), r);
    applyStimulus(7'd8, 0, 32'(sx), r);
    m_kernel = kl; m_depth = d; m_offset = off; m_startx = sx;
  endtask

  task automatic checkStatus(input string tag);
    logic [31:0] r;
    applyStimulus(7'd9, 0, 0, r);
    checkOutput(tag, r, {30'b0, m_error, 1'b1});
  endtask

  // Start a convolution, act as quant block with the given latency, check all.
  task automatic runConv(input string tag, input int quant_lat, input logic [31:0] qret);
    logic [31:0] r;
    logic [31:0] exp_acc;
    int beats;
    int cycles;
    exp_acc = modelConv();
    beats   = (m_kernel * m_depth + LANES - 1) / LANES;
    applyStimulus(7'd6, 0, 0, r);
    cycles = 0;
    while (!quant_start && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " cycles to quant_start"}, cycles, beats + 1);
    checkOutput({tag, " quant_acc"}, quant_acc, exp_acc);
    checkOutput({tag, " busy in quant"}, 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, " quant_start pulse"}, 32'(quant_start), 32'd0);
    repeat (quant_lat - 1) @(negedge clk);
    quant_done = 1'b1; quant_ret = qret;
    @(negedge clk);
    quant_done = 1'b0; quant_ret = '0;
    checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
    applyStimulus(7'd7, 0, 0, r);
    checkOutput({tag, " result"}, r, qret);
    last_result = qret;
    checkStatus({tag, " status"});
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r;
    int cycles;
    int kl;
    int d;

    reset = 1'b1; en = 1'b0; cmd = NOP; inp0 = '0; inp1 = '0;
    quant_done = 1'b0; quant_ret = '0;
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("reset ret", ret, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset quant_start", 32'(quant_start), 32'd0);
    checkOutput("reset acc out", quant_acc, 32'd0);
    applyStimulus(7'd0, 0, 0, r);
    checkOutput("info filt depth", r, 32'(FILT_DEPTH));
    en = 1'b0; cmd = 7'd9;
    @(negedge clk);
    checkOutput("en low holds ret", ret, 32'(FILT_DEPTH));
    en = 1'b1; cmd = NOP;
    checkStatus("reset status");
    applyStimulus(7'd7, 0, 0, r);
    checkOutput("reset result", r, 32'd0);
    applyStimulus(7'd11, 0, 0, r);
    checkOutput("reset acc", r, 32'd0);
    applyStimulus(7'd4, 0, 0, r);
    checkOutput("undefined cmd ret", r, 32'd0);

    $display("[TB] directed convolutions");
    configure(8, 1, 0, 0);
    fillBuf(1'b1, 8, 0, 1);
    fillBuf(1'b0, 12, 1, 1);
    runConv("A depth1", 3, 32'h0000_0A5A);

    configure(5, 3, 128, 0);
    fillBuf(1'b1, 16, 0, -1);
    fillBuf(1'b0, 20, 0, -128);
    runConv("B masked tail", 1, 32'hFFFF_FF80);

    configure(4, 2, 0, 3);
    fillBuf(1'b1, 8, 0, 1);
    fillBuf(1'b0, 12, 1, 0);
    runConv("C ring wrap", 2, 32'h0000_0024);

    $display("[TB] configuration errors");
    applyStimulus(7'd5, 0, 0, r);
    m_error = 1'b1;
    checkStatus("depth 0 rejected");
    applyStimulus(7'd13, 0, 0, r);
    m_error = 1'b0;
    checkStatus("error cleared");
    applyStimulus(7'd5, 0, 129, r);
    applyStimulus(7'd10, 0, 0, r);
    applyStimulus(7'd10, 0, 9, r);
    m_error = 1'b1;
    checkStatus("depth/kernel out of range");
    applyStimulus(7'd13, 0, 0, r);
    m_error = 1'b0;
    runConv("C config kept", 1, 32'h0000_1111);

    applyStimulus(7'd8, 0, 5, r);
    m_startx = 5;
    applyStimulus(7'd6, 0, 0, r);
    m_error = 1'b1;
    checkOutput("start_x too big busy", 32'(busy), 32'd0);
    checkStatus("start_x too big status");
    applyStimulus(7'd13, 0, 0, r);
    m_error = 1'b0;
    configure(1, 3, 0, 0);
    applyStimulus(7'd6, 0, 0, r);
    m_error = 1'b1;
    checkOutput("small ring busy", 32'(busy), 32'd0);
    checkStatus("small ring status");
    applyStimulus(7'd13, 0, 0, r);
    m_error = 1'b0;

    writeWord(1'b0, RING_DEPTH - 2, 32'h4433_2211);
    checkStatus("ring write overflow");
    writeWord(1'b1, FILT_DEPTH - 1, 32'h8877_6655);
    checkStatus("filt write overflow");
    applyStimulus(7'd13, 0, 0, r);
    m_error = 1'b0;

    $display("[TB] randomized convolutions");
    for (int it = 0; it < 5; it++) begin
      kl = int'($urandom_range(1, MAX_KERNEL));
      d  = int'($urandom_range(1, 12));
      if ((kl + 1) * d < LANES) d = (LANES + kl) / (kl + 1);
      configure(kl, d, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, kl)));
      fillBuf(1'b1, kl * d, 2, 0);
      fillBuf(1'b0, (kl + 1) * d, 2, 0);
      runConv($sformatf("random %0d", it), int'($urandom_range(1, 4)), $urandom);
    end

    $display("[TB] full-size convolution");
    configure(8, 128, 127, 0);
    fillBuf(1'b1, FILT_DEPTH, 0, 127);
    fillBuf(1'b0, RING_DEPTH, 0, 127);
    runConv("full size", 4, 32'h0000_7F7F);

    $display("[TB] reset mid-MAC and abort in QUANT");
    applyStimulus(7'd6, 0, 0, r);
    applyStimulus(7'd3, 0, 5, r);
    m_error = 1'b1;
    applyStimulus(7'd9, 0, 0, r);
    checkOutput("status while busy", r, {30'b0, m_error, 1'b0});
    checkOutput("busy mid-MAC", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset quant_start", 32'(quant_start), 32'd0);
    checkStatus("mid reset status");
    applyStimulus(7'd11, 0, 0, r);
    checkOutput("mid reset acc", r, 32'd0);
    runConv("after reset", 2, 32'h1234_5678);

    applyStimulus(7'd6, 0, 0, r);
    cycles = 0;
    while (!quant_start && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("abort run reaches quant", cycles, 32'd2);
    en = 1'b1; cmd = 7'd12; quant_done = 1'b1; quant_ret = 32'hDEAD_BEEF;
    @(negedge clk);
    cmd = NOP; quant_done = 1'b0; quant_ret = '0;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort quant_start", 32'(quant_start), 32'd0);
    checkStatus("abort status");
    applyStimulus(7'd7, 0, 0, r);
    checkOutput("abort keeps result", r, last_result);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
